wave_sweep_ctrl: RTL and testbench

- Sequencer for one wave_unit datapath over an N-cell field held in an external synchronous RAM pair (u, du).
- Streams cells through a 3-wide sliding window, so every update in a sweep uses old neighbour values. Writes results back in place and applies Neumann copy at both edges.
- Counts iterations and pauses at sweep boundaries so the UART frame transmitter gets exclusive, consistent access to the field.

---
 rtl/wave_sweep_ctrl_if.sv | 40 ++++
 rtl/wave_sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_wave_sweep_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_sweep_ctrl_if.sv
// Bus bundle between the sweep controller, the field RAM pair (u, du) and
// the wave_unit datapath.
//   mem_raddr/mem_re            read port request (data valid next cycle)
//   mem_u_rdata/mem_du_rdata    read data
//   mem_waddr/mem_we/*_wdata    write port (u and du written together)
//   mem_grant                   RAM free for other masters
//   wu_u/wu_du/wu_uL/wu_uR      wave_unit operands
//   wu_u_new/wu_du_new          wave_unit results (combinational)
interface wave_sweep_ctrl_if #(
  parameter int W  = 32,
  parameter int AW = 5
);
  logic [AW-1:0] mem_raddr;
  logic          mem_re;
  logic [W-1:0]  mem_u_rdata;
  logic [W-1:0]  mem_du_rdata;
  logic [AW-1:0] mem_waddr;
  logic          mem_we;
  logic [W-1:0]  mem_u_wdata;
  logic [W-1:0]  mem_du_wdata;
  logic          mem_grant;
  logic [W-1:0]  wu_u;
  logic [W-1:0]  wu_du;
  logic [W-1:0]  wu_uL;
  logic [W-1:0]  wu_uR;
  logic [W-1:0]  wu_u_new;
  logic [W-1:0]  wu_du_new;

  modport master (
    output mem_raddr, mem_re, mem_waddr, mem_we, mem_u_wdata, mem_du_wdata,
           mem_grant, wu_u, wu_du, wu_uL, wu_uR,
    input  mem_u_rdata, mem_du_rdata, wu_u_new, wu_du_new
  );

  modport slave (
    input  mem_raddr, mem_re, mem_waddr, mem_we, mem_u_wdata, mem_du_wdata,
           mem_grant, wu_u, wu_du, wu_uL, wu_uR,
    output mem_u_rdata, mem_du_rdata, wu_u_new, wu_du_new
  );
endinterface

// File: rtl/wave_sweep_ctrl.sv
// Sweep sequencer for one wave_unit over an N_CELLS field in external
// synchronous RAM. Cells stream through a 3-wide window so each update sees
// old neighbours; results are written back in place and both edge cells get
// a Neumann copy. Pauses at sweep boundaries on frame_hold.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, run_iters     run request pulse and sweep count (latched)
//   frame_hold           pause request, sampled at sweep boundary
//   bus                  RAM / wave_unit bundle (master side)
//   busy, sweep_done     run in progress, per-sweep completion pulse
//   iter_count           sweeps completed in the current run
//
// state | meaning
// IDLE  | waiting for start
// PRIME | 4 cycles: read cells 0..2 into the window
// SWEEP | N_CELLS-2 cycles: update cells 1..N_CELLS-2, one per cycle
// EDGE  | 2 cycles: Neumann copy into cells 0 and N_CELLS-1
// WAIT  | paused between sweeps, RAM granted to transmitter
// DONE  | run finished, one cycle then IDLE
module wave_sweep_ctrl #(
  parameter int N_CELLS = 20,
  parameter int W       = 32,
  parameter int AW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          run_iters,
  input  logic                 frame_hold,
  wave_sweep_ctrl_if.master    bus,
  output logic                 busy,
  output logic                 sweep_done,
  output logic [15:0]          iter_count
);

  typedef enum logic [2:0] {IDLE, PRIME, SWEEP, EDGE, WAIT, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CELLS - 1);
  localparam logic [AW-1:0] SWEEP_END = AW'(N_CELLS - 3);
  localparam logic [AW-1:0] READ_END  = AW'(N_CELLS - 4);

  state_t        state, state_next;
  logic [AW-1:0] cyc;
  logic [15:0]   iters_q;
  logic [15:0]   iter_next;
  logic          rd_vld;
  logic [W-1:0]  win_uL, win_u, win_uR, win_du, win_duR;
  logic [W-1:0]  eff_uR, eff_duR;
  logic [W-1:0]  edge_l, edge_r;

  assign iter_next = iter_count + 16'd1;

  // Inside SWEEP the right neighbour arrives straight from the RAM in the
  // same cycle it is used; only the first sweep cell uses the primed value.
  assign eff_uR  = rd_vld ? bus.mem_u_rdata  : win_uR;
  assign eff_duR = rd_vld ? bus.mem_du_rdata : win_duR;

  assign bus.wu_uL = win_uL;
  assign bus.wu_u  = win_u;
  assign bus.wu_du = win_du;
  assign bus.wu_uR = eff_uR;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.mem_re       = 1'b0;
    bus.mem_raddr    = '0;
    bus.mem_we       = 1'b0;
    bus.mem_waddr    = '0;
    bus.mem_u_wdata  = '0;
    bus.mem_du_wdata = '0;
    bus.mem_grant    = 1'b1;
    busy             = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (run_iters == 16'd0) ? DONE : PRIME;
      end
      PRIME: begin
        busy          = 1'b1;
        bus.mem_grant = 1'b0;
        if (cyc < AW'(3)) begin
          bus.mem_re    = 1'b1;
          bus.mem_raddr = cyc;
        end
        if (cyc == AW'(3)) state_next = SWEEP;
      end
      SWEEP: begin
        busy             = 1'b1;
        bus.mem_grant    = 1'b0;
        bus.mem_we       = 1'b1;
        bus.mem_waddr    = cyc + AW'(1);
        bus.mem_u_wdata  = bus.wu_u_new;
        bus.mem_du_wdata = bus.wu_du_new;
        if (cyc <= READ_END) begin
          bus.mem_re    = 1'b1;
          bus.mem_raddr = cyc + AW'(3);
        end
        if (cyc == SWEEP_END) state_next = EDGE;
      end
      EDGE: begin
        busy          = 1'b1;
        bus.mem_grant = 1'b0;
        bus.mem_we    = 1'b1;
        if (cyc == '0) begin
          bus.mem_waddr   = '0;
          bus.mem_u_wdata = edge_l;
        end else begin
          bus.mem_waddr   = LAST_ADDR;
          bus.mem_u_wdata = edge_r;
          // Run completion wins over a pending pause request.
          if (iter_next == iters_q) state_next = DONE;
          else if (frame_hold)      state_next = WAIT;
          else                      state_next = PRIME;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (!frame_hold) state_next = PRIME;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc        <= '0;
      iters_q    <= '0;
      iter_count <= '0;
      sweep_done <= 1'b0;
      rd_vld     <= 1'b0;
      win_uL     <= '0;
      win_u      <= '0;
      win_uR     <= '0;
      win_du     <= '0;
      win_duR    <= '0;
      edge_l     <= '0;
      edge_r     <= '0;
    end else begin
      rd_vld     <= bus.mem_re;
      sweep_done <= (state == EDGE) && (cyc != '0);
      cyc        <= (state_next != state) ? '0 : cyc + AW'(1);

      if (state == IDLE && start) begin
        iters_q    <= run_iters;
        iter_count <= '0;
      end
      if (state == EDGE && cyc != '0) iter_count <= iter_next;

      if (state == PRIME && rd_vld) begin
        win_uL  <= win_u;
        win_u   <= win_uR;
        win_uR  <= bus.mem_u_rdata;
        win_du  <= win_duR;
        win_duR <= bus.mem_du_rdata;
      end

      if (state == SWEEP) begin
        win_uL <= win_u;
        win_u  <= eff_uR;
        win_du <= eff_duR;
        if (cyc == '0)       edge_l <= bus.wu_u_new;
        if (cyc == SWEEP_END) edge_r <= bus.wu_u_new;
      end
    end
  end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
module tb_wave_sweep_ctrl;
  localparam int N  = 20;
  localparam int W  = 32;
  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] run_iters;
  logic        frame_hold;
  logic        busy;
  logic        sweep_done;
  logic [15:0] iter_count;

  wave_sweep_ctrl_if #(.W(W), .AW(AW)) bus ();

  wave_sweep_ctrl #(.N_CELLS(N), .W(W), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run_iters  (run_iters),
    .frame_hold (frame_hold),
    .bus        (bus),
    .busy       (busy),
    .sweep_done (sweep_done),
    .iter_count (iter_count)
  );

  always #5 clk = ~clk;

  // Reference wave_unit: du' = du + (uL + uR - 2u) >>> 2 ; u' = u + du'
  logic signed [W-1:0] m_lap, m_du_new;
  assign m_lap         = $signed(bus.wu_uL) + $signed(bus.wu_uR) - ($signed(bus.wu_u) <<< 1);
  assign m_du_new      = $signed(bus.wu_du) + (m_lap >>> 2);
  assign bus.wu_du_new = m_du_new;
  assign bus.wu_u_new  = $signed(bus.wu_u) + m_du_new;

  // Field RAM pair with synchronous read, plus access counters.
  logic signed [W-1:0] ram_u [N];
  logic signed [W-1:0] ram_du [N];
  logic signed [W-1:0] init_u [N];
  logic signed [W-1:0] init_du [N];
  logic signed [W-1:0] gu [N];
  logic signed [W-1:0] gdu [N];
  logic load_req = 1'b0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) begin
        ram_u[i]  <= init_u[i];
        ram_du[i] <= init_du[i];
      end
    end else if (bus.mem_we) begin
      ram_u[bus.mem_waddr]  <= bus.mem_u_wdata;
      ram_du[bus.mem_waddr] <= bus.mem_du_wdata;
    end
    if (bus.mem_re) begin
      bus.mem_u_rdata  <= ram_u[bus.mem_raddr];
      bus.mem_du_rdata <= ram_du[bus.mem_raddr];
    end
    if (bus.mem_re) rd_cnt <= rd_cnt + 1;
    if (bus.mem_we) wr_cnt <= wr_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_field(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: begin
          init_u[i]  = (i >= 11 && i <= 14) ? 32'sd200000000 : 32'sd0;
          init_du[i] = 32'sd0;
        end
        1: begin
          init_u[i]  = 32'(i * 1000 - 7000);
          init_du[i] = 32'((i % 3) * 50 - 40);
        end
        default: begin
          init_u[i]  = (i % 2 == 1) ? 32'sd123456789 : -32'sd98765432;
          init_du[i] = 32'(i * 7 - 60);
        end
      endcase
      gu[i]  = init_u[i];
      gdu[i] = init_du[i];
    end
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  // Jacobi step on the golden arrays using only old neighbour values.
  task automatic golden_sweep();
    logic signed [W-1:0] nu [N];
    logic signed [W-1:0] nd [N];
    for (int i = 1; i < N - 1; i++) begin
      nd[i] = gdu[i] + ((gu[i-1] + gu[i+1] - (gu[i] <<< 1)) >>> 2);
      nu[i] = gu[i] + nd[i];
    end
    nu[0]   = nu[1];
    nd[0]   = 32'sd0;
    nu[N-1] = nu[N-2];
    nd[N-1] = 32'sd0;
    for (int i = 0; i < N; i++) begin
      gu[i]  = nu[i];
      gdu[i] = nd[i];
    end
  endtask

  task automatic compare_field(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < N; i++)
      if (ram_u[i] !== gu[i] || ram_du[i] !== gdu[i]) mism++;
    check({tag, "_field"}, 64'(mism), 64'(0));
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.mem_re, bus.mem_we, sweep_done, busy, bus.mem_grant}), 64'(5'b00001));
    check({tag, "_iter"}, 64'(iter_count), 64'(0));
    check({tag, "_addr"}, 64'({bus.mem_raddr, bus.mem_waddr}), 64'(0));
    check({tag, "_wdata"}, {bus.mem_u_wdata, bus.mem_du_wdata}, 64'(0));
    check({tag, "_wu"}, {bus.wu_u | bus.wu_du, bus.wu_uL | bus.wu_uR}, 64'(0));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!sweep_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] iters;
    int          pat;
    bit          disturb;
    int          exp_done;
    int          exp_busy;
    int          exp_first;
    int          exp_rw;
  } vec_t;

  task automatic run_and_check(input vec_t v, input string tag);
    int idx, n_done, first, last, gap, busy_c, rd0, wr0;
    bit ended;
    load_field(v.pat);
    for (int s = 0; s < int'(v.iters); s++) golden_sweep();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    run_iters = v.iters;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    idx    = 0;
    n_done = 0;
    first  = -1;
    last   = -1;
    gap    = 24;
    busy_c = 0;
    ended  = 1'b0;
    for (int c = 0; c < 3000 && !ended; c++) begin
      if (sweep_done) begin
        if (last >= 0) gap = idx - last;
        else           first = idx;
        last = idx;
        n_done++;
      end
      if (busy) busy_c++;
      else      ended = 1'b1;
      if (v.disturb) begin
        case (idx)
          8:  frame_hold = 1'b1;
          9:  frame_hold = 1'b0;
          30: begin start = 1'b1; run_iters = 16'd9; end
          31: begin start = 1'b0; run_iters = v.iters; end
          default: ;
        endcase
      end
      if (!ended) begin
        @(posedge clk);
        #1;
        idx++;
      end
    end
    check({tag, "_ended"}, 64'(ended), 64'(1));
    check({tag, "_iter"}, 64'(iter_count), 64'(v.iters));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      if (sweep_done) n_done++;
      if (busy) busy_c++;
    end
    check({tag, "_ndone"}, 64'(n_done), 64'(v.exp_done));
    check({tag, "_busy"}, 64'(busy_c), 64'(v.exp_busy));
    check({tag, "_first"}, 64'(first), 64'(v.exp_first));
    if (v.exp_done >= 2) check({tag, "_gap"}, 64'(gap), 64'(24));
    check({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(v.exp_rw));
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(v.exp_rw));
    compare_field(tag);
    if (v.iters != 16'd0) begin
      check({tag, "_edge0"}, 64'({ram_u[0], ram_du[0]}), 64'({gu[1], 32'sd0}));
      check({tag, "_edgeN"}, 64'({ram_u[N-1], ram_du[N-1]}), 64'({gu[N-2], 32'sd0}));
    end
  endtask

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad, r1, w1, rd0, wr0;
    vec_t post;

    tbl[0] = '{iters: 16'd1, pat: 0, disturb: 1'b0, exp_done: 1, exp_busy: 24, exp_first: 24, exp_rw: 20};
    tbl[1] = '{iters: 16'd0, pat: 0, disturb: 1'b0, exp_done: 0, exp_busy: 0,  exp_first: -1, exp_rw: 0};
    tbl[2] = '{iters: 16'd2, pat: 1, disturb: 1'b0, exp_done: 2, exp_busy: 48, exp_first: 24, exp_rw: 40};
    tbl[3] = '{iters: 16'd3, pat: 2, disturb: 1'b1, exp_done: 3, exp_busy: 72, exp_first: 24, exp_rw: 60};
    tbl[4] = '{iters: 16'd1, pat: 2, disturb: 1'b0, exp_done: 1, exp_busy: 24, exp_first: 24, exp_rw: 20};

    rst        = 1'b1;
    start      = 1'b0;
    run_iters  = 16'd0;
    frame_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_rst_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) run_and_check(tbl[t], $sformatf("vec%0d", t));

    // frame_hold held high for a 3-sweep run: pause after sweeps 1 and 2 only.
    load_field(1);
    for (int s = 0; s < 3; s++) golden_sweep();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    frame_hold = 1'b1;
    run_iters  = 16'd3;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    run_iters = 16'd0;
    for (int s = 1; s <= 3; s++) begin
      wait_done(lat);
      check($sformatf("hold_lat%0d", s), 64'(lat), 64'(24));
      check($sformatf("hold_iter%0d", s), 64'(iter_count), 64'(s));
      if (s < 3) begin
        check($sformatf("hold_wait%0d", s), 64'({busy, bus.mem_grant}), 64'(2'b11));
        r1  = rd_cnt;
        w1  = wr_cnt;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
          if (s == 1 && c == 1) begin start = 1'b1; run_iters = 16'd1; end
          else start = 1'b0;
          @(posedge clk);
          #1;
          if (!(busy && bus.mem_grant)) bad++;
        end
        start = 1'b0;
        check($sformatf("hold_stay%0d", s), 64'(bad), 64'(0));
        check($sformatf("hold_noram%0d", s), 64'((rd_cnt - r1) + (wr_cnt - w1)), 64'(0));
        frame_hold = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("hold_resume%0d", s), 64'({busy, bus.mem_grant, bus.mem_re}), 64'(3'b101));
        frame_hold = 1'b1;
      end else begin
        check("hold_done", 64'({busy, bus.mem_grant}), 64'(2'b01));
      end
    end
    frame_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_rw", 64'({rd_cnt - rd0, wr_cnt - wr0}), 64'({32'd60, 32'd60}));
    compare_field("hold");

    // Reset during the second sweep at SWEEP k=5.
    load_field(1);
    wr0 = wr_cnt;
    @(negedge clk);
    run_iters = 16'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("rst_pre_iter", 64'(iter_count), 64'(1));
    check("rst_pre_we", 64'({bus.mem_we, bus.mem_waddr}), 64'({1'b1, 5'd6}));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_writes", 64'(wr_cnt - wr0), 64'(26));
    check_rst_outputs("rst_mid");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_after", 64'({bus.mem_we, bus.mem_re, busy, sweep_done}), 64'(0));

    post = '{iters: 16'd1, pat: 0, disturb: 1'b0, exp_done: 1, exp_busy: 24, exp_first: 24, exp_rw: 20};
    run_and_check(post, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
